// File: rtl/reg_bank_arbiter.sv
// Write arbiter for the 9 x 8-bit time/date register bank.
// Serialises RTC and PicoBlaze writes; protects PB-owned registers while editing.
module reg_bank_arbiter #(
    parameter int NUM_REGS = 9,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rtc_req,
    input  logic [ADDR_W-1:0]   rtc_addr,
    input  logic [DATA_W-1:0]   rtc_data,
    output logic                rtc_ack,
    input  logic                pb_req,
    input  logic [ADDR_W-1:0]   pb_addr,
    input  logic [DATA_W-1:0]   pb_data,
    output logic                pb_ack,
    input  logic                edit_mode,
    input  logic [NUM_REGS-1:0] lock_mask,
    output logic [NUM_REGS-1:0] en_reg,
    output logic [DATA_W-1:0]   data_reg,
    output logic                sel_rtc_pb,
    output logic                addr_err,
    output logic [7:0]          drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t state;

    // 1 = PicoBlaze held the last grant, so RTC wins the next tie
    logic last_grant;

    logic                grant_pb;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REGS-1:0] win_hot;
    logic                lock_hit;
    logic                bad_addr;

    // Pick the winner and decode its address; an out-of-range address
    // decodes to no enable at all, which also masks the lock check.
    always_comb begin
        grant_pb = 1'b0;
        if (pb_req && (!rtc_req || !last_grant)) begin
            grant_pb = 1'b1;
        end
        win_addr = grant_pb ? pb_addr : rtc_addr;
        win_data = grant_pb ? pb_data : rtc_data;
        win_hot  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            win_hot[i] = (win_addr == ADDR_W'(i));
        end
        lock_hit = !grant_pb && edit_mode && |(lock_mask & win_hot);
        bad_addr = ~|win_hot;
    end

    // Grant FSM with registered strobes: IDLE -> WRITE -> RECOVER -> IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            en_reg     <= '0;
            data_reg   <= '0;
            rtc_ack    <= 1'b0;
            pb_ack     <= 1'b0;
            sel_rtc_pb <= 1'b0;
            addr_err   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rtc_req || pb_req) begin
                        state      <= WRITE;
                        last_grant <= grant_pb;
                        sel_rtc_pb <= grant_pb;
                        data_reg   <= win_data;
                        en_reg     <= lock_hit ? '0 : win_hot;
                        rtc_ack    <= !grant_pb;
                        pb_ack     <= grant_pb;
                        addr_err   <= bad_addr;
                        if (lock_hit && drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end
                end
                WRITE: begin
                    state    <= RECOVER;
                    en_reg   <= '0;
                    rtc_ack  <= 1'b0;
                    pb_ack   <= 1'b0;
                    addr_err <= 1'b0;
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    en_reg   <= '0;
                    rtc_ack  <= 1'b0;
                    pb_ack   <= 1'b0;
                    addr_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_bank_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       rtc_req, pb_req;
    logic [3:0] rtc_addr, pb_addr;
    logic [7:0] rtc_data, pb_data;
    logic       rtc_ack, pb_ack;
    logic       edit_mode;
    logic [8:0] lock_mask;
    logic [8:0] en_reg;
    logic [7:0] data_reg;
    logic       sel_rtc_pb, addr_err;
    logic [7:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_bank_arbiter dut (
        .clk(clk), .reset(reset),
        .rtc_req(rtc_req), .rtc_addr(rtc_addr), .rtc_data(rtc_data),
        .rtc_ack(rtc_ack),
        .pb_req(pb_req), .pb_addr(pb_addr), .pb_data(pb_data),
        .pb_ack(pb_ack),
        .edit_mode(edit_mode), .lock_mask(lock_mask),
        .en_reg(en_reg), .data_reg(data_reg), .sel_rtc_pb(sel_rtc_pb),
        .addr_err(addr_err), .drop_cnt(drop_cnt)
    );

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // drop both requests and let WRITE and RECOVER run out
    task automatic release_reqs();
        rtc_req = 1'b0;
        pb_req  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rtc_req = 1'b0; pb_req = 1'b0;
        rtc_addr = '0; pb_addr = '0; rtc_data = '0; pb_data = '0;
        edit_mode = 1'b0; lock_mask = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({en_reg, data_reg, rtc_ack, pb_ack, sel_rtc_pb, addr_err, drop_cnt}
            !== 30'd0) begin
            failures++;
            $display("FAIL reset_outputs en=%b data=%h acks=%b%b sel=%b err=%b drop=%0d exp all 0",
                     en_reg, data_reg, rtc_ack, pb_ack, sel_rtc_pb, addr_err, drop_cnt);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_rtc();
        rtc_req = 1'b1; rtc_addr = 4'd3; rtc_data = 8'h45;
        @(negedge clk);
        checks++;
        if (en_reg !== 9'b000001000 || data_reg !== 8'h45 || rtc_ack !== 1'b1
            || pb_ack !== 1'b0 || sel_rtc_pb !== 1'b0) begin
            failures++;
            $display("FAIL single_rtc en=%b data=%h rack=%b pack=%b sel=%b exp 000001000 45 1 0 0",
                     en_reg, data_reg, rtc_ack, pb_ack, sel_rtc_pb);
        end
        @(negedge clk);
        checks++;
        if (en_reg !== 9'd0 || rtc_ack !== 1'b0 || data_reg !== 8'h45) begin
            failures++;
            $display("FAIL recover_quiet en=%b ack=%b data=%h exp 0 0 45",
                     en_reg, rtc_ack, data_reg);
        end
        @(negedge clk);
        checks++;
        if (en_reg !== 9'd0) begin
            failures++;
            $display("FAIL back_in_idle en=%b exp 0", en_reg);
        end
        @(negedge clk);
        checks++;
        if (en_reg !== 9'b000001000 || rtc_ack !== 1'b1) begin
            failures++;
            $display("FAIL three_cycle_rate en=%b ack=%b exp 000001000 1",
                     en_reg, rtc_ack);
        end
        release_reqs();
    endtask

    task automatic test_round_robin();
        reset = 1'b0;
        rtc_req = 1'b1; rtc_addr = 4'd2; rtc_data = 8'hA0;
        pb_req  = 1'b1; pb_addr  = 4'd5; pb_data  = 8'hB0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic       exp_pb;
            logic [8:0] exp_en;
            exp_pb = (k % 2) == 1;
            exp_en = exp_pb ? 9'b000100000 : 9'b000000100;
            @(negedge clk);
            checks++;
            if (en_reg !== exp_en || pb_ack !== exp_pb || rtc_ack !== !exp_pb
                || sel_rtc_pb !== exp_pb
                || data_reg !== (exp_pb ? 8'hB0 : 8'hA0)) begin
                failures++;
                $display("FAIL round_robin_%0d en=%b pack=%b rack=%b sel=%b data=%h exp en=%b pb=%b",
                         k, en_reg, pb_ack, rtc_ack, sel_rtc_pb, data_reg, exp_en, exp_pb);
            end
            repeat (2) @(negedge clk);
        end
        release_reqs();
    endtask

    task automatic test_lock();
        edit_mode = 1'b1; lock_mask = 9'h007;
        rtc_req = 1'b1; rtc_addr = 4'd1; rtc_data = 8'h77;
        @(negedge clk);
        checks++;
        if (rtc_ack !== 1'b1 || en_reg !== 9'd0 || addr_err !== 1'b0) begin
            failures++;
            $display("FAIL lock_suppress ack=%b en=%b err=%b exp 1 0 0",
                     rtc_ack, en_reg, addr_err);
        end
        release_reqs();
        checks++;
        if (drop_cnt !== 8'd1) begin
            failures++;
            $display("FAIL drop_count_one got=%0d exp=1", drop_cnt);
        end
        pb_req = 1'b1; pb_addr = 4'd1; pb_data = 8'h12;
        @(negedge clk);
        checks++;
        if (pb_ack !== 1'b1 || en_reg !== 9'b000000010 || data_reg !== 8'h12
            || sel_rtc_pb !== 1'b1) begin
            failures++;
            $display("FAIL pb_not_locked ack=%b en=%b data=%h sel=%b exp 1 000000010 12 1",
                     pb_ack, en_reg, data_reg, sel_rtc_pb);
        end
        release_reqs();
        rtc_req = 1'b1; rtc_addr = 4'd4; rtc_data = 8'h33;
        @(negedge clk);
        checks++;
        if (en_reg !== 9'b000010000 || data_reg !== 8'h33) begin
            failures++;
            $display("FAIL unlocked_rtc en=%b data=%h exp 000010000 33", en_reg, data_reg);
        end
        release_reqs();
        rtc_req = 1'b1; rtc_addr = 4'd10; rtc_data = 8'h99;
        @(negedge clk);
        checks++;
        if (rtc_ack !== 1'b1 || addr_err !== 1'b1 || en_reg !== 9'd0) begin
            failures++;
            $display("FAIL lock_bad_addr ack=%b err=%b en=%b exp 1 1 0",
                     rtc_ack, addr_err, en_reg);
        end
        release_reqs();
        checks++;
        if (drop_cnt !== 8'd1) begin
            failures++;
            $display("FAIL bad_addr_no_drop got=%0d exp=1", drop_cnt);
        end
        edit_mode = 1'b0;
        rtc_req = 1'b1; rtc_addr = 4'd0; rtc_data = 8'h01;
        @(negedge clk);
        checks++;
        if (en_reg !== 9'b000000001) begin
            failures++;
            $display("FAIL edit_off_write en=%b exp 000000001", en_reg);
        end
        release_reqs();
    endtask

    task automatic test_saturate();
        edit_mode = 1'b1; lock_mask = 9'h007;
        rtc_req = 1'b1; rtc_addr = 4'd0; rtc_data = 8'h55;
        repeat (900) @(negedge clk);
        release_reqs();
        @(negedge clk);
        checks++;
        if (drop_cnt !== 8'd255) begin
            failures++;
            $display("FAIL drop_saturate got=%0d exp=255", drop_cnt);
        end
        edit_mode = 1'b0; lock_mask = '0;
    endtask

    task automatic test_bad_addr();
        pb_req = 1'b1; pb_addr = 4'd9; pb_data = 8'hC3;
        @(negedge clk);
        checks++;
        if (pb_ack !== 1'b1 || addr_err !== 1'b1 || en_reg !== 9'd0) begin
            failures++;
            $display("FAIL pb_addr9 ack=%b err=%b en=%b exp 1 1 0",
                     pb_ack, addr_err, en_reg);
        end
        @(negedge clk);
        checks++;
        if (addr_err !== 1'b0) begin
            failures++;
            $display("FAIL addr_err_pulse got=%b exp=0", addr_err);
        end
        release_reqs();
        pb_req = 1'b1; pb_addr = 4'd8; pb_data = 8'h3C;
        @(negedge clk);
        checks++;
        if (en_reg !== 9'b100000000 || addr_err !== 1'b0 || data_reg !== 8'h3C) begin
            failures++;
            $display("FAIL pb_addr8 en=%b err=%b data=%h exp 100000000 0 3c",
                     en_reg, addr_err, data_reg);
        end
        release_reqs();
    endtask

    task automatic test_reset_abort();
        pb_req = 1'b1; pb_addr = 4'd6; pb_data = 8'h66;
        @(negedge clk);
        checks++;
        if (en_reg !== 9'b001000000) begin
            failures++;
            $display("FAIL abort_setup en=%b exp 001000000", en_reg);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({en_reg, data_reg, rtc_ack, pb_ack, sel_rtc_pb, addr_err, drop_cnt}
            !== 30'd0) begin
            failures++;
            $display("FAIL reset_abort en=%b data=%h acks=%b%b sel=%b err=%b drop=%0d exp all 0",
                     en_reg, data_reg, rtc_ack, pb_ack, sel_rtc_pb, addr_err, drop_cnt);
        end
        rtc_req = 1'b1; rtc_addr = 4'd7; rtc_data = 8'h70;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (rtc_ack !== 1'b1 || pb_ack !== 1'b0 || sel_rtc_pb !== 1'b0
            || en_reg !== 9'b010000000) begin
            failures++;
            $display("FAIL rtc_first_after_reset rack=%b pack=%b sel=%b en=%b exp 1 0 0 010000000",
                     rtc_ack, pb_ack, sel_rtc_pb, en_reg);
        end
        release_reqs();
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_single_rtc();
        test_round_robin();
        test_lock();
        test_saturate();
        test_bad_addr();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
